// File: rtl/div_pkg.sv
// Shared types and widths for the sequential 16/8 restoring divider.
// State encodings are fixed because state_out drives the seven-segment display.
package div_pkg;

    localparam int unsigned DIVIDEND_W = 16;
    localparam int unsigned DIVISOR_W  = 8;
    localparam int unsigned ITER_LAST  = 15;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_DONE  = 3'd2,
        ST_DZERO = 3'd3
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// The 9-bit trial value never exceeds 2*divisor-1, so the kept remainder fits in 8 bits.
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] rem,
    input  logic                 shift_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] rem_next,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] trial;

    always_comb begin
        trial    = {rem, shift_bit};
        q_bit    = (trial >= {1'b0, divisor});
        rem_next = q_bit ? DIVISOR_W'(trial - {1'b0, divisor}) : trial[DIVISOR_W-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential 16/8 unsigned restoring divider producing one quotient bit per clock.
// Results load only on entry to DONE/DZERO and are held until the next result.
module seq_divider
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_a,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    input  logic                  start,
    output logic                  done_flag,
    output logic                  div_zero,
    output logic [DIVIDEND_W-1:0] quotient_out,
    output logic [DIVISOR_W-1:0]  remainder_out,
    output logic [STATE_W-1:0]    state_out
);

    state_t                state;
    state_t                state_nxt;
    logic [DIVIDEND_W-1:0] q_sh;
    logic [DIVISOR_W-1:0]  dvsr;
    logic [DIVISOR_W-1:0]  rem;
    logic [DIVISOR_W-1:0]  rem_next;
    logic                  q_bit;
    logic [CNT_W-1:0]      cnt;
    logic                  last_iter;
    logic                  load_ops;
    logic                  load_dz;
    logic                  step;
    logic                  load_result;
    logic                  done_nxt;
    logic                  dz_nxt;

    assign last_iter = (cnt == CNT_W'(ITER_LAST));

    div_step u_step (
        .rem       (rem),
        .shift_bit (q_sh[DIVIDEND_W-1]),
        .divisor   (dvsr),
        .rem_next  (rem_next),
        .q_bit     (q_bit)
    );

    // State register
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured outside CALC
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CALC: begin
                if (last_iter) begin
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? ST_DZERO : ST_CALC;
                end
            end
        endcase
    end

    // Datapath controls and next values of the registered status flags
    always_comb begin
        load_ops    = 1'b0;
        load_dz     = 1'b0;
        step        = 1'b0;
        load_result = 1'b0;
        case (state)
            ST_CALC: begin
                step        = 1'b1;
                load_result = last_iter;
            end
            default: begin
                if (start) begin
                    if (divisor == '0) begin
                        load_dz = 1'b1;
                    end else begin
                        load_ops = 1'b1;
                    end
                end
            end
        endcase
        done_nxt = (state_nxt == ST_DONE) || (state_nxt == ST_DZERO);
        dz_nxt   = (state_nxt == ST_DZERO);
    end

    // Working registers and result/status outputs
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            q_sh          <= '0;
            dvsr          <= '0;
            rem           <= '0;
            cnt           <= '0;
            quotient_out  <= '0;
            remainder_out <= '0;
            done_flag     <= 1'b0;
            div_zero      <= 1'b0;
        end else begin
            done_flag <= done_nxt;
            div_zero  <= dz_nxt;
            if (load_ops) begin
                q_sh <= dividend;
                dvsr <= divisor;
                rem  <= '0;
                cnt  <= '0;
            end else if (step) begin
                q_sh <= {q_sh[DIVIDEND_W-2:0], q_bit};
                rem  <= rem_next;
                cnt  <= cnt + CNT_W'(1);
            end
            if (load_result) begin
                quotient_out  <= {q_sh[DIVIDEND_W-2:0], q_bit};
                remainder_out <= rem_next;
            end else if (load_dz) begin
                quotient_out  <= '1;
                remainder_out <= '0;
            end
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a transaction-level reference (plain / and %)
// checked every cycle, plus hand-computed literal results for each scenario.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset_a = 1'b1;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        start = 1'b0;
    logic        done_flag;
    logic        div_zero;
    logic [15:0] quotient_out;
    logic [7:0]  remainder_out;
    logic [2:0]  state_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_divider dut (
        .clk           (clk),
        .reset_a       (reset_a),
        .dividend      (dividend),
        .divisor       (divisor),
        .start         (start),
        .done_flag     (done_flag),
        .div_zero      (div_zero),
        .quotient_out  (quotient_out),
        .remainder_out (remainder_out),
        .state_out     (state_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: phase 0 idle, 1 busy, 2 done, 3 divide-by-zero; result appears 16 edges after capture
    int          m_phase;
    int          m_left;
    logic [15:0] m_q, m_pq;
    logic [7:0]  m_r, m_pr;

    always @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            m_phase <= 0;
            m_left  <= 0;
            m_q     <= '0;
            m_r     <= '0;
            m_pq    <= '0;
            m_pr    <= '0;
        end else if (m_phase == 1) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_phase <= 2;
                m_q     <= m_pq;
                m_r     <= m_pr;
            end
        end else if (start) begin
            if (divisor == 8'd0) begin
                m_phase <= 3;
                m_q     <= 16'hFFFF;
                m_r     <= 8'h00;
            end else begin
                m_phase <= 1;
                m_left  <= 16;
                m_pq    <= dividend / 16'(divisor);
                m_pr    <= 8'(dividend % 16'(divisor));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_a) begin
            check("model_done", 32'(done_flag), 32'((m_phase == 2) || (m_phase == 3)));
            check("model_dz", 32'(div_zero), 32'(m_phase == 3));
            check("model_state", 32'(state_out), 32'(m_phase));
            check("model_quot", 32'(quotient_out), 32'(m_q));
            check("model_rem", 32'(remainder_out), 32'(m_r));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic launch(input logic [15:0] dd, input logic [7:0] dv);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        cyc();
        start    = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [15:0] q, input logic [7:0] r,
                                 input logic [2:0] st, input logic dz);
        check({name, "_done"}, 32'(done_flag), 32'd1);
        check({name, "_dz"}, 32'(div_zero), 32'(dz));
        check({name, "_quot"}, 32'(quotient_out), 32'(q));
        check({name, "_rem"}, 32'(remainder_out), 32'(r));
        check({name, "_state"}, 32'(state_out), 32'(st));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("reset_done", 32'(done_flag), 32'd0);
        check("reset_dz", 32'(div_zero), 32'd0);
        check("reset_quot", 32'(quotient_out), 32'd0);
        check("reset_rem", 32'(remainder_out), 32'd0);
        check("reset_state", 32'(state_out), 32'd0);
        reset_a = 1'b0;
        cyc();

        // 1000 / 7 with a one-cycle start pulse
        launch(16'd1000, 8'd7);
        check("t1_calc_state", 32'(state_out), 32'd1);
        repeat (15) cyc();
        check("t1_not_yet", 32'(done_flag), 32'd0);
        cyc();
        expect_result("t1", 16'd142, 8'd6, 3'd2, 1'b0);
        repeat (2) cyc();
        expect_result("t1_hold", 16'd142, 8'd6, 3'd2, 1'b0);

        // 0xFFFF / 0xFF then 0xFFFF / 1; previous quotient held through CALC
        launch(16'hFFFF, 8'hFF);
        repeat (16) cyc();
        expect_result("t2a", 16'h0101, 8'h00, 3'd2, 1'b0);
        launch(16'hFFFF, 8'h01);
        repeat (8) cyc();
        check("t2_mid_quot", 32'(quotient_out), 32'h0101);
        check("t2_mid_done", 32'(done_flag), 32'd0);
        repeat (8) cyc();
        expect_result("t2b", 16'hFFFF, 8'h00, 3'd2, 1'b0);

        // Divide by zero, then a normal division from DZERO
        launch(16'h1234, 8'h00);
        expect_result("t3_dz", 16'hFFFF, 8'h00, 3'd3, 1'b1);
        repeat (3) cyc();
        expect_result("t3_dz_hold", 16'hFFFF, 8'h00, 3'd3, 1'b1);
        launch(16'h1234, 8'h10);
        check("t3_dz_fall", 32'(div_zero), 32'd0);
        check("t3_done_fall", 32'(done_flag), 32'd0);
        repeat (16) cyc();
        expect_result("t3", 16'h0123, 8'h04, 3'd2, 1'b0);

        // 500 / 9 with start toggling and operands changing during CALC
        launch(16'd500, 8'd9);
        for (int i = 0; i < 15; i++) begin
            start    = i[0];
            dividend = 16'($urandom);
            divisor  = 8'(i);
            cyc();
        end
        start = 1'b0;
        cyc();
        expect_result("t4", 16'd55, 8'd5, 3'd2, 1'b0);

        // Reset in the middle of CALC, then 200 / 3
        launch(16'd1000, 8'd7);
        repeat (8) cyc();
        reset_a = 1'b1;
        #1;
        check("t5_rst_done", 32'(done_flag), 32'd0);
        check("t5_rst_quot", 32'(quotient_out), 32'd0);
        check("t5_rst_rem", 32'(remainder_out), 32'd0);
        check("t5_rst_state", 32'(state_out), 32'd0);
        @(posedge clk);
        #2;
        check("t5_rst_hold", 32'(state_out), 32'd0);
        reset_a = 1'b0;
        cyc();
        launch(16'd200, 8'd3);
        repeat (16) cyc();
        expect_result("t5", 16'd66, 8'd2, 3'd2, 1'b0);

        // start held high across three back-to-back operations
        dividend = 16'd100;
        divisor  = 8'd10;
        start    = 1'b1;
        cyc();
        repeat (16) cyc();
        expect_result("t6a", 16'd10, 8'd0, 3'd2, 1'b0);
        dividend = 16'd7;
        divisor  = 8'd8;
        cyc();
        check("t6a_pulse", 32'(done_flag), 32'd0);
        repeat (16) cyc();
        expect_result("t6b", 16'd0, 8'd7, 3'd2, 1'b0);
        dividend = 16'd255;
        divisor  = 8'd255;
        cyc();
        check("t6b_pulse", 32'(done_flag), 32'd0);
        repeat (16) cyc();
        expect_result("t6c", 16'd1, 8'd0, 3'd2, 1'b0);
        start = 1'b0;
        cyc();
        expect_result("t6c_hold", 16'd1, 8'd0, 3'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
